// File: rtl/periph_bus_pkg.sv
// Shared definitions for the simple peripheral bus master: FSM encoding,
// bus width defaults and the default grant-wait limit.
package periph_bus_pkg;

    localparam int BUS_AW                 = 32;
    localparam int BUS_DW                 = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/periph_bus_master.sv
// Converts a valid/ready command stream into single transactions on the
// simple peripheral bus. Optional grant timeout: PERIPH_BUS_MASTER_TIMEOUT_EN.
module periph_bus_master
    import periph_bus_pkg::*;
#(
    parameter int AW             = BUS_AW,
    parameter int DW             = BUS_DW,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          req_o,
    input  logic          grant_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    input  logic [DW-1:0] data_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("periph_bus_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_e        state_q, state_d;
    logic          cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          accept;
    logic          granted;
    logic          timeout;

    assign accept  = (state_q == IDLE) && cmd_valid_i;
    assign granted = (state_q == REQ) && grant_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output and next-state term gets a default first, so no
    // path through the case leaves a signal unassigned (no latch inferred).
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        req_o       = 1'b0;
        we_o        = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = REQ;
            end
            REQ: begin
                req_o = 1'b1;
                // Write strobe only in a granted cycle, so exactly one bus write.
                we_o  = cmd_we_q & grant_i;
                if (grant_i || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                cmd_we_q    <= cmd_we_i;
                cmd_addr_q  <= cmd_addr_i;
                cmd_wdata_q <= cmd_wdata_i;
            end
            // Grant wins over a timeout landing in the same cycle.
            if (granted) begin
                rsp_rdata_q <= cmd_we_q ? '0 : data_i;
            end else if (timeout) begin
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef PERIPH_BUS_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] wait_cnt_q;
    logic          rsp_err_q;

    assign timeout = (state_q == REQ) && !grant_i &&
                     (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt_q <= '0;
            end else if ((state_q == REQ) && !grant_i) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (granted) begin
                rsp_err_q <= 1'b0;
            end else if (timeout) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    assign addr_o      = cmd_addr_q;
    assign data_o      = cmd_wdata_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master: table-driven commands with a
// response scoreboard, plus backpressure, reset-abort and loopback sequences.
module tb_periph_bus_master;

`ifdef PERIPH_BUS_MASTER_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif
    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gdelay;
        logic [31:0] sval;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req, grant, we;
    logic [31:0] addr, data_out, data_in;

    logic        loopback = 1'b0;
    logic [31:0] slave_rdata = '0;
    logic [31:0] loop_reg = '0;

    int          req_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;

    int   total = 0;
    int   bad = 0;
    rsp_t exp_q[$];
    vec_t vecs[6];

    periph_bus_master #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .req_o(req), .grant_i(grant), .we_o(we),
        .addr_o(addr), .data_o(data_out), .data_i(data_in)
    );

    always #5 clk = ~clk;

    // Slave: either a fixed read value or a one-word loopback register.
    assign data_in = loopback ? loop_reg : slave_rdata;
    always @(posedge clk) if (we) loop_reg <= data_out;

    always @(negedge clk) begin
        if (req) req_cnt <= req_cnt + 1;
        if (we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= addr;
            we_data <= data_out;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input int gdelay, input logic [31:0] sval, input int hold,
                          input bit press);
        bit   to;
        int   exp_req, k, req0, we0;
        rsp_t e, got;
        to      = (TO_EN != 0) && (gdelay >= TO);
        exp_req = to ? TO : gdelay + 1;
        e.rdata = (to || w) ? 32'h0 : sval;
        e.err   = to;
        check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_valid   = 1'b1;
        cmd_we      = w;
        cmd_addr    = a;
        cmd_wdata   = wd;
        slave_rdata = sval;
        grant       = (gdelay == 0);
        exp_q.push_back(e);
        req0 = req_cnt;
        we0  = we_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 300) begin
            grant = (k >= gdelay);
            @(posedge clk); #1;
            k++;
        end
        grant = 1'b0;
        check("req_cycles_to_rsp", 64'(k), 64'(exp_req));
        check("req_high_cycles", 64'(req_cnt - req0), 64'(exp_req));
        check("we_pulses", 64'(we_cnt - we0), (w && !to) ? 64'd1 : 64'd0);
        if (w && !to) begin
            check("we_addr", {32'd0, we_addr}, {32'd0, a});
            check("we_data", {32'd0, we_data}, {32'd0, wd});
        end
        got = exp_q.pop_front();
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, got.rdata});
        check("rsp_err", {63'd0, rsp_err}, {63'd0, got.err});
        for (int i = 0; i < hold; i++) begin
            slave_rdata = ~sval;
            if (press) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = 32'hF0;
                cmd_wdata = 32'h5555_AAAA;
            end
            @(posedge clk); #1;
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_rdata", {32'd0, rsp_rdata}, {32'd0, got.rdata});
            check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_dropped", {63'd0, rsp_valid}, 64'd0);
        check("no_early_accept", {63'd0, req}, 64'd0);
    endtask

    initial begin
        int we0;
        vecs[0] = '{1'b1, 32'h4,  32'hA5A5_0001, 0,  32'hDEAD_BEEF, 0};
        vecs[1] = '{1'b0, 32'h0,  32'h0,         5,  32'h0000_0003, 0};
        vecs[2] = '{1'b0, 32'h8,  32'h0,         1,  32'h1234_5678, 2};
        vecs[3] = '{1'b1, 32'hC,  32'hFFFF_FFFF, 2,  32'h0000_0055, 0};
        vecs[4] = '{1'b0, 32'h10, 32'h0,         3,  32'h0BAD_F00D, 0};
        vecs[5] = '{1'b0, 32'h14, 32'h0,         20, 32'h0000_0077, 1};

        rst = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; grant = 1'b0;
        #3;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_req", {63'd0, req}, 64'd0);
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_outs", {rsp_rdata, addr}, 64'd0);
        check("rst_data_err", {31'd0, rsp_err, data_out}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            do_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gdelay,
                   vecs[i].sval, vecs[i].hold, 1'b0);

        // Backpressure with a competing command held on the input.
        do_cmd(1'b0, 32'h18, 32'h0, 0, 32'h0000_CAFE, 10, 1'b1);
        do_cmd(1'b1, 32'h1C, 32'h0000_0042, 0, 32'h0, 0, 1'b0);

        // Reset while a granted write is pending in REQ.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h99;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        grant = 1'b1;
        #1;
        check("pre_rst_req", {63'd0, req}, 64'd1);
        check("pre_rst_we", {63'd0, we}, 64'd1);
        we0 = we_cnt;
        #1 rst = 1'b0;
        #1;
        check("async_req_drop", {63'd0, req}, 64'd0);
        check("async_we_drop", {63'd0, we}, 64'd0);
        check("async_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        check("post_rst_no_write", 64'(we_cnt - we0), 64'd0);
        grant = 1'b0;

        // Back-to-back write then read through the loopback slave.
        loopback = 1'b1;
        do_cmd(1'b1, 32'h4, 32'h1, 0, 32'h0, 0, 1'b0);
        total++;
        if (loop_reg !== 32'h1) begin
            bad++;
            $display("FAIL loop_write: got %0h expected 1", loop_reg);
        end
        exp_q.push_back('{32'h1, 1'b0});
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4;
        check("b2b_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        grant = 1'b1;
        @(posedge clk); #1;
        grant = 1'b0;
        check("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        begin
            rsp_t got;
            got = exp_q.pop_front();
            check("b2b_read_data", {32'd0, rsp_rdata}, {32'd0, got.rdata});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
